// File: rtl/ustc_dn_feeder_pkg.sv
// Shared widths for the ustc_dn distribution network and its feeder, plus the
// feeder presentation-state encoding.
package ustc_dn_feeder_pkg;

    localparam int DN_DW_DATA = 8;
    localparam int DN_DW_IDX  = 3;
    localparam int DN_N_IN    = 1 << DN_DW_IDX;
    localparam int DN_N_OUT   = 32;
    localparam int DN_DW_HOLD = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } feeder_state_e;

endpackage

// File: rtl/ustc_dn_feeder_bank.sv
// One staging bank of the feeder: holds a complete operand set
// {data, lane indices, effective hold count} until it is overwritten.
module ustc_dn_feeder_bank
    import ustc_dn_feeder_pkg::*;
#(
    parameter int W_DATA = DN_N_IN * DN_DW_DATA,
    parameter int W_IDX  = DN_N_OUT * DN_DW_IDX,
    parameter int W_HOLD = DN_DW_HOLD
) (
    input  logic              clk,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [W_DATA-1:0] data_i,
    input  logic [W_IDX-1:0]  idx_i,
    input  logic [W_HOLD-1:0] hold_i,
    output logic [W_DATA-1:0] data_o,
    output logic [W_IDX-1:0]  idx_o,
    output logic [W_HOLD-1:0] hold_o
);

    logic [W_DATA-1:0] data_q;
    logic [W_IDX-1:0]  idx_q;
    logic [W_HOLD-1:0] hold_q;

    // Capture a set on write enable; synchronous clear drops any stale set.
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            data_q <= '0;
            idx_q  <= '0;
            hold_q <= '0;
        end else if (we_i) begin
            data_q <= data_i;
            idx_q  <= idx_i;
            hold_q <= hold_i;
        end
    end

    assign data_o = data_q;
    assign idx_o  = idx_q;
    assign hold_o = hold_q;

endmodule

// File: rtl/ustc_dn_feeder.sv
// Ping-pong staging buffer in front of ustc_dn. One bank is presented (held
// for its hold count) while the other refills, so sets run back-to-back.
//
//   state | meaning
//   IDLE  | no stored set, dn_valid low, outputs keep last presented values
//   SHOW  | presenting the set in bank[rd_ptr]; hold_q counts cycles left
module ustc_dn_feeder
    import ustc_dn_feeder_pkg::*;
#(
    parameter int DW_DATA = DN_DW_DATA,
    parameter int DW_IDX  = DN_DW_IDX,
    parameter int N_IN    = DN_N_IN,
    parameter int N_OUT   = DN_N_OUT,
    parameter int DW_HOLD = DN_DW_HOLD
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [N_IN*DW_DATA-1:0] s_data,
    input  logic [N_OUT*DW_IDX-1:0] s_idx,
    input  logic [DW_HOLD-1:0]      s_hold,
    output logic [N_IN*DW_DATA-1:0] dn_in,
    output logic [N_OUT*DW_IDX-1:0] dn_idx,
    output logic                    dn_valid,
    output logic                    dn_first
);

    localparam int W_DATA = N_IN * DW_DATA;
    localparam int W_IDX  = N_OUT * DW_IDX;

    feeder_state_e      state_q;
    logic [1:0]         cnt_q;
    logic [1:0]         cnt_d;
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [DW_HOLD-1:0] hold_q;
    logic [W_DATA-1:0]  dn_in_q;
    logic [W_IDX-1:0]   dn_idx_q;
    logic               dn_valid_q;
    logic               dn_first_q;

    logic               accept;
    logic               release_set;
    logic [DW_HOLD-1:0] s_hold_eff;

    logic [W_DATA-1:0]  bank_data [2];
    logic [W_IDX-1:0]   bank_idx  [2];
    logic [DW_HOLD-1:0] bank_hold [2];

    logic [W_DATA-1:0]  nxt_data;
    logic [W_IDX-1:0]   nxt_idx;
    logic [DW_HOLD-1:0] nxt_hold;

    // Ready looks only at the registered fill level; a release in the same
    // cycle does not open a slot early.
    assign s_ready     = (cnt_q != 2'd2) && reset;
    assign accept      = s_valid && s_ready;
    assign release_set = (state_q == SHOW) && (hold_q == DW_HOLD'(1));
    assign s_hold_eff  = (s_hold == '0) ? DW_HOLD'(1) : s_hold;
    assign cnt_d       = cnt_q + {1'b0, accept} - {1'b0, release_set};

    for (genvar g = 0; g < 2; g++) begin : g_bank
        ustc_dn_feeder_bank #(
            .W_DATA (W_DATA),
            .W_IDX  (W_IDX),
            .W_HOLD (DW_HOLD)
        ) u_bank (
            .clk     (clk),
            .rst_n_i (reset),
            .we_i    (accept && (int'(wr_ptr_q) == g)),
            .data_i  (s_data),
            .idx_i   (s_idx),
            .hold_i  (s_hold_eff),
            .data_o  (bank_data[g]),
            .idx_o   (bank_idx[g]),
            .hold_o  (bank_hold[g])
        );
    end

    // The set that follows: the waiting bank when both are full, otherwise the
    // set being accepted right now (its bank write lands on the same edge).
    always_comb begin
        if (cnt_q == 2'd2) begin
            nxt_data = bank_data[~rd_ptr_q];
            nxt_idx  = bank_idx[~rd_ptr_q];
            nxt_hold = bank_hold[~rd_ptr_q];
        end else begin
            nxt_data = s_data;
            nxt_idx  = s_idx;
            nxt_hold = s_hold_eff;
        end
    end

    // Presentation FSM with pointers, fill count and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            hold_q     <= '0;
            dn_in_q    <= '0;
            dn_idx_q   <= '0;
            dn_valid_q <= 1'b0;
            dn_first_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (release_set) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case (state_q)
                IDLE: begin
                    dn_first_q <= 1'b0;
                    if (accept) begin
                        state_q    <= SHOW;
                        hold_q     <= nxt_hold;
                        dn_in_q    <= nxt_data;
                        dn_idx_q   <= nxt_idx;
                        dn_valid_q <= 1'b1;
                        dn_first_q <= 1'b1;
                    end
                end
                SHOW: begin
                    if (release_set) begin
                        if ((cnt_q == 2'd2) || accept) begin
                            hold_q     <= nxt_hold;
                            dn_in_q    <= nxt_data;
                            dn_idx_q   <= nxt_idx;
                            dn_first_q <= 1'b1;
                        end else begin
                            state_q    <= IDLE;
                            dn_valid_q <= 1'b0;
                            dn_first_q <= 1'b0;
                        end
                    end else begin
                        hold_q     <= hold_q - DW_HOLD'(1);
                        dn_first_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dn_in    = dn_in_q;
    assign dn_idx   = dn_idx_q;
    assign dn_valid = dn_valid_q;
    assign dn_first = dn_first_q;

endmodule
